// File: rtl/param_serializer.sv
// param_serializer
//   Transmit side of the parameter serial link. On an accepted start the
//   NWORDS x WIDTH parameter block is snapshotted, then sent as a framed
//   serial stream: 16-bit SYNC header, data words (word 0 first, MSB first),
//   an optional CRC-16-CCITT, one idle gap bit period and a one-cycle done.
//
//   Optional feature macro: PARAM_SERIALIZER_CRC_EN
//     defined   -> CRC-16-CCITT (poly 0x1021, init 0xFFFF) over data bits is
//                  appended after the data words.
//     undefined -> no CRC state or logic; the gap follows the data directly.
//
//   Handshake: start_in is a level request sampled only while the block is
//   idle (IDLE state or the DONE cycle); requests arriving while busy are
//   dropped, never queued. busy_out covers the whole frame including the
//   gap, and drops in the DONE cycle where done_out pulses.
//
// Ports
//   clk_in        system clock
//   rst_in        asynchronous reset, active-high
//   start_in      frame request
//   params_in     packed words, word k = params_in[k*WIDTH +: WIDTH]
//   busy_out      frame in progress
//   done_out      one-cycle end-of-frame pulse
//   ser_data_out  serial data, MSB first, changes at start of a bit period
//   ser_clk_out   bit clock, low first half / high second half of a period
//   ser_trig_out  frame enable, high during every transmitted bit
//   dbg_state     current FSM state (observation only)

module param_serializer #(
  parameter int          NWORDS = 12,
  parameter int          WIDTH  = 35,
  parameter int          CLKDIV = 4,
  parameter logic [15:0] SYNC   = 16'hA5C3
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [NWORDS*WIDTH-1:0]   params_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      ser_data_out,
  output logic                      ser_clk_out,
  output logic                      ser_trig_out,
  output logic [2:0]                dbg_state
);

  localparam int DBITS = NWORDS * WIDTH;
`ifdef PARAM_SERIALIZER_CRC_EN
  localparam int CBITS = 16;
`else
  localparam int CBITS = 0;
`endif
  localparam int B   = 16 + DBITS + CBITS;   // total bits per frame
  localparam int BW  = $clog2(B + 1);
  localparam int PER = 2 * CLKDIV;           // clk_in cycles per bit
  localparam int DW  = $clog2(PER);
  localparam int SW  = 16 + DBITS;           // shadow holds SYNC + words

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CRC  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] shadow;
  logic [DBITS-1:0] ordered;
  logic [BW-1:0] next_idx;
  logic          period_end;
  logic          last_bit;

`ifdef PARAM_SERIALIZER_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Word 0 is placed at the top of the shadow so a plain left shift emits
  // word 0 first, each word MSB first, right after the SYNC header.
  always_comb begin
    ordered = '0;
    for (int k = 0; k < NWORDS; k++) begin
      ordered[(NWORDS-1-k)*WIDTH +: WIDTH] = params_in[k*WIDTH +: WIDTH];
    end
  end

  assign next_idx   = bit_cnt + BW'(1);
  assign period_end = (div_cnt == DW'(PER - 1));
  assign last_bit   = (bit_cnt == BW'(B - 1));
  assign dbg_state  = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shadow       <= '0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      ser_data_out <= 1'b0;
      ser_clk_out  <= 1'b0;
      ser_trig_out <= 1'b0;
`ifdef PARAM_SERIALIZER_CRC_EN
      crc          <= '0;
`endif
    end else begin
      case (state)
        // The DONE cycle also accepts a start so a held request restarts
        // with only that single cycle between frames.
        S_IDLE, S_DONE: begin
          done_out <= 1'b0;
          if (start_in) begin
            state        <= S_SYNC;
            shadow       <= {SYNC, ordered};
            ser_data_out <= SYNC[15];
            ser_trig_out <= 1'b1;
            ser_clk_out  <= 1'b0;
            busy_out     <= 1'b1;
            div_cnt      <= '0;
            bit_cnt      <= '0;
`ifdef PARAM_SERIALIZER_CRC_EN
            crc          <= 16'hFFFF;
`endif
          end else begin
            state <= S_IDLE;
          end
        end

`ifdef PARAM_SERIALIZER_CRC_EN
        S_SYNC, S_DATA, S_CRC: begin
`else
        S_SYNC, S_DATA: begin
`endif
          if (!period_end) begin
            div_cnt <= div_cnt + DW'(1);
            // Rising edge lands on the first cycle of the second half.
            if (div_cnt == DW'(CLKDIV - 1)) ser_clk_out <= 1'b1;
          end else begin
            div_cnt     <= '0;
            ser_clk_out <= 1'b0;
            if (last_bit) begin
              bit_cnt      <= '0;
              state        <= S_GAP;
              ser_trig_out <= 1'b0;
              ser_data_out <= 1'b0;
            end else begin
              bit_cnt <= next_idx;
              // ser_data_out always mirrors shadow[SW-1]; advancing emits
              // the next bit in line.
              if (next_idx < BW'(SW)) begin
                ser_data_out <= shadow[SW-2];
                shadow       <= shadow << 1;
                if (next_idx == BW'(16)) state <= S_DATA;
`ifdef PARAM_SERIALIZER_CRC_EN
                if (next_idx >= BW'(16)) crc <= crc_step(crc, shadow[SW-2]);
`endif
              end
`ifdef PARAM_SERIALIZER_CRC_EN
              else begin
                // crc already folds in the last data bit; shift it out.
                ser_data_out <= crc[15];
                crc          <= {crc[14:0], 1'b0};
                if (next_idx == BW'(SW)) state <= S_CRC;
              end
`endif
            end
          end
        end

        S_GAP: begin
          if (period_end) begin
            div_cnt  <= '0;
            state    <= S_DONE;
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        default: begin
          state        <= S_IDLE;
          div_cnt      <= '0;
          bit_cnt      <= '0;
          shadow       <= '0;
          busy_out     <= 1'b0;
          done_out     <= 1'b0;
          ser_data_out <= 1'b0;
          ser_clk_out  <= 1'b0;
          ser_trig_out <= 1'b0;
`ifdef PARAM_SERIALIZER_CRC_EN
          crc          <= '0;
`endif
        end
      endcase
    end
  end

endmodule
